dbus_burst_arb: RTL and testbench
=================================

// Module: dbus_burst_arb
// PURPOSE
//  Round-robin arbiter merging N Versat data-bus masters onto the single
//  burst-capable databus port of the external-memory DMA (databus_* / dma_len).
//  Grants one master per burst, locks the grant for len+1 beats, then rotates.
//  Sits between the Versat engine's memory-side ports and ext_mem.
// PARAMETERS
//  N_MASTERS  3   number of requesting masters (2..8)
//  ADDR_W     32  address width per master
//  DATA_W     32  data width per beat (multiple of 8)
//  LEN_W      8   burst length field width; burst = len+1 beats
// PORTS
//  clk        in   1               system clock
//  rst        in   1               synchronous reset, active-low
//  m_valid    in   N_MASTERS       per-master request
//  m_addr     in   N_MASTERS*ADDR_W    per-master address (burst start)
//  m_wdata    in   N_MASTERS*DATA_W    per-master write data
//  m_wstrb    in   N_MASTERS*DATA_W/8  per-master strobe; all-zero = read
//  m_len      in   N_MASTERS*LEN_W     per-master burst length-1
//  m_rdata    out  DATA_W          read data, broadcast to all masters
//  m_ready    out  N_MASTERS       per-master beat acknowledge
//  s_valid    out  1               request to DMA
//  s_addr     out  ADDR_W          address of granted master
//  s_wdata    out  DATA_W          write data of granted master
//  s_wstrb    out  DATA_W/8        strobe of granted master
//  s_len      out  LEN_W           latched burst length of granted master
//  s_rdata    in   DATA_W          read data from DMA
//  s_ready    in   1               beat acknowledge from DMA
//  grant      out  N_MASTERS       one-hot current owner (0 = none)
//  busy       out  1               burst in progress
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state=IDLE, grant=0, busy=0, beat_cnt=0,
//    rr_ptr=0, len_q=0. With grant=0: s_valid=0, s_addr/wdata/wstrb/len=0,
//    m_ready=0. m_rdata = s_rdata always (unregistered pass-through).
//  - States: IDLE -> BUSY -> IDLE.
//  - IDLE: if any m_valid, select first valid index at or after rr_ptr
//    (wrapping mod N_MASTERS); register grant, len_q=m_len[sel], beat_cnt=0,
//    busy=1 -> BUSY. Arbitration latency: 1 cycle from m_valid to s_valid.
//  - BUSY: s_* = granted master's fields (combinational mux by grant),
//    s_len = len_q; s_valid = m_valid[g]; m_ready[g] = s_ready & s_valid,
//    all other m_ready = 0.
//  - Beat accepted when s_valid & s_ready: beat_cnt++. On the accepted beat
//    with beat_cnt==len_q: grant=0, busy=0, rr_ptr=(g+1) mod N -> IDLE.
//    One idle cycle always separates bursts (no back-to-back grant).
//  - Granted master dropping m_valid mid-burst: s_valid follows to 0, grant
//    and beat_cnt held; burst resumes when valid returns. Never abandoned.
//  - Non-granted masters' m_valid changes during BUSY ignored.
//  - len_q latched at grant; changes to m_len[g] during burst ignored.
//  - len=0: single-beat burst, released on first accepted beat.
//  - beat_cnt is LEN_W bits; cannot wrap because release occurs at len_q.
//  - Simultaneous requests: strict RR from rr_ptr; a master just served is
//    lowest priority for the next grant.
//  - Reset mid-burst: immediate return to reset state on next edge; the
//    DMA side is reset by the same rst.
// CONFIGURATION
//  DBUS_ARB_FIXED_PRIO_EN defined: rr_ptr unused (held 0); IDLE always picks
//   lowest-index valid master (master 0 highest priority).
//  Not defined: round-robin as above.
// TESTING
//  1 Reset: rst=0 4 cycles with all m_valid=1 -> grant=0, s_valid=0, m_ready=0.
//  2 Single read: m0 valid, addr=0x100, len=3, wstrb=0, s_ready=1 -> s_valid
//    1 cycle later, 4 m_ready[0] pulses, grant=3'b001 then 0, busy 4 cycles.
//  3 RR: all 3 valid, len=0, s_ready=1 -> grant order 001,010,100,001 with
//    one idle cycle between each.
//  4 Stall: m1 burst len=7, s_ready toggles 1/0, m1 drops valid beats 3-4
//    -> exactly 8 accepted beats, grant held throughout, rr_ptr=2 after.
//  5 Reset mid-burst: rst=0 at beat 2 of len=5 -> next cycle grant=0,
//    busy=0; after release, m2 request granted first (rr_ptr=0 -> m0 absent).
//  6 FIXED_PRIO_EN: m0 and m2 continuously valid, len=1 -> m0 granted every
//    burst, m2 never granted.

Source files
------------

// File: rtl/dbus_burst_arb.sv
// dbus_burst_arb: round-robin arbiter that merges N Versat data-bus masters
// onto the single burst-capable databus port of the external-memory DMA.
// One master owns the bus for a whole burst of len+1 accepted beats. The
// owner then moves to the lowest round-robin priority.
// Build option: define DBUS_ARB_FIXED_PRIO_EN to switch to fixed priority.
// In that mode master 0 has the highest priority and the rotation pointer
// stays at 0.
module dbus_burst_arb #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  input  logic [N_MASTERS*LEN_W-1:0]      m_len,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  output logic [LEN_W-1:0]                s_len,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_ready,
  output logic [N_MASTERS-1:0]            grant,
  output logic                            busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(N_MASTERS);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t               r_state;
  logic [N_MASTERS-1:0] r_grant;
  logic                 r_busy;
  logic [LEN_W-1:0]     r_beat_cnt;
  logic [LEN_W-1:0]     r_len_q;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_gidx;

  logic                 w_any;
  logic [PTR_W-1:0]     w_sel;
  logic [PTR_W-1:0]     w_cand;
  int                   w_j;

  // Pick the first requesting master at or after the rotation pointer.
  // The pointer never moves in fixed-priority mode, so this becomes a
  // lowest-index-wins search.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = '0;
    w_cand = '0;
    w_j    = 0;
    for (int i = 0; i < N_MASTERS; i++) begin
      w_j = int'(r_rr_ptr) + i;
      if (w_j >= N_MASTERS) w_j = w_j - N_MASTERS;
      w_cand = PTR_W'(w_j);
      if (!w_any && m_valid[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  // Route the owner's request fields to the DMA and steer the beat
  // acknowledge back to the owner. Read data is broadcast unregistered.
  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    s_len   = '0;
    if (r_busy) begin
      s_valid = m_valid[r_gidx];
      s_addr  = m_addr[r_gidx*ADDR_W +: ADDR_W];
      s_wdata = m_wdata[r_gidx*DATA_W +: DATA_W];
      s_wstrb = m_wstrb[r_gidx*STRB_W +: STRB_W];
      s_len   = r_len_q;
    end
    m_ready = r_grant & {N_MASTERS{s_valid & s_ready}};
    m_rdata = s_rdata;
    grant   = r_grant;
    busy    = r_busy;
  end

  // Grant/release FSM. The grant is held until the last beat is accepted.
  // A master that drops valid mid-burst only stalls the burst. Release
  // always passes through IDLE, which leaves one dead cycle between bursts.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_beat_cnt <= '0;
      r_len_q    <= '0;
      r_rr_ptr   <= '0;
      r_gidx     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant    <= N_MASTERS'(1) << w_sel;
            r_gidx     <= w_sel;
            r_len_q    <= m_len[w_sel*LEN_W +: LEN_W];
            r_beat_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (s_valid && s_ready) begin
            if (r_beat_cnt == r_len_q) begin
              r_grant    <= '0;
              r_busy     <= 1'b0;
              r_beat_cnt <= '0;
`ifndef DBUS_ARB_FIXED_PRIO_EN
              r_rr_ptr   <= (r_gidx == PTR_W'(N_MASTERS - 1)) ? '0 : r_gidx + 1'b1;
`endif
              r_state    <= S_IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_burst_arb.sv
// Self-checking bench for dbus_burst_arb (3 masters, 32-bit address/data,
// 8-bit length). Expected beats are queued when a request is driven and
// popped when the arbiter acknowledges a beat.
module tb_dbus_burst_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  m_valid;
  logic [95:0] m_addr;
  logic [95:0] m_wdata;
  logic [11:0] m_wstrb;
  logic [23:0] m_len;
  logic [31:0] m_rdata;
  logic [2:0]  m_ready;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [7:0]  s_len;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [2:0]  grant;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          mst;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t exp_q[$];

  dbus_burst_arb #(.N_MASTERS(3), .ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_len(m_len),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_len(s_len),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic set_master(input int m, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input logic [7:0] len);
    m_addr[m*32 +: 32] = addr;
    m_wdata[m*32 +: 32] = wd;
    m_wstrb[m*4 +: 4]   = strb;
    m_len[m*8 +: 8]     = len;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_valid = 3'b111;
    s_ready = 1'b1;
    for (int m = 0; m < 3; m++) set_master(m, 32'h40 * (m + 1), 32'h55 + m, 4'hF, 8'd2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      s_rdata = $urandom;
      #1;
      checks++; if (grant !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b exp=000", grant); end
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid got=%b exp=0", s_valid); end
      checks++; if (m_ready !== 3'b000) begin failures++; $display("FAIL reset_m_ready got=%b exp=000", m_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (s_addr !== 32'h0 || s_len !== 8'h0) begin failures++; $display("FAIL reset_s_fields got=%h/%h exp=0/0", s_addr, s_len); end
      checks++; if (m_rdata !== s_rdata) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", m_rdata, s_rdata); end
    end
    @(negedge clk);
    rst = 1'b1;
    m_valid = 3'b000;
  endtask

  task automatic test_single_read();
    beat_t e;
    int pulses = 0;
    int busy_cyc = 0;
    bit done = 0;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back('{0, 32'h100, 32'h0});
    @(negedge clk);
    set_master(0, 32'h100, 32'h0, 4'h0, 8'd3);
    m_valid = 3'b001;
    s_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (pulses == 4) m_valid = 3'b000;
      s_rdata = $urandom;
      #1;
      checks++; if (m_rdata !== s_rdata) begin failures++; $display("FAIL single_rdata got=%h exp=%h", m_rdata, s_rdata); end
      if (cyc == 0) begin
        checks++; if (s_valid !== 1'b1 || grant !== 3'b001) begin failures++; $display("FAIL single_latency got=%b/%b exp=1/001", s_valid, grant); end
      end
      if (busy === 1'b1) busy_cyc++;
      if (pulses == 4) begin
        checks++; if (grant !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL single_release got=%b/%b exp=000/0", grant, busy); end
        done = 1;
      end else if (m_ready !== 3'b000) begin
        pulses++;
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL single_extra_beat got=%b exp=none", m_ready);
        end else begin
          e = exp_q.pop_front();
          checks++; if (m_ready !== 3'(1 << e.mst)) begin failures++; $display("FAIL single_ready got=%b exp=%b", m_ready, 3'(1 << e.mst)); end
          checks++; if (s_addr !== e.addr || s_wstrb !== 4'h0 || s_len !== 8'd3) begin failures++; $display("FAIL single_fields got=%h/%h/%h exp=%h/0/3", s_addr, s_wstrb, s_len, e.addr); end
        end
      end
    end
    checks++; if (pulses != 4) begin failures++; $display("FAIL single_pulses got=%0d exp=4", pulses); end
    checks++; if (busy_cyc != 4) begin failures++; $display("FAIL single_busy_cycles got=%0d exp=4", busy_cyc); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_rr();
    beat_t e;
    int beats = 0;
    bit prev_beat = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int m = 0; m < 3; m++) set_master(m, 32'h1000 * (m + 1), 32'h0, 4'hF, 8'd0);
    exp_q.push_back('{0, 32'h1000, 32'h0});
    exp_q.push_back('{1, 32'h2000, 32'h0});
    exp_q.push_back('{2, 32'h3000, 32'h0});
    exp_q.push_back('{0, 32'h1000, 32'h0});
    m_valid = 3'b111;
    s_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && beats < 4; cyc++) begin
      @(negedge clk);
      #1;
      if (prev_beat) begin
        checks++; if (grant !== 3'b000) begin failures++; $display("FAIL rr_idle_gap got=%b exp=000", grant); end
      end
      prev_beat = (m_ready !== 3'b000);
      if (prev_beat && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        beats++;
        checks++; if (m_ready !== 3'(1 << e.mst)) begin failures++; $display("FAIL rr_order got=%b exp=%b", m_ready, 3'(1 << e.mst)); end
        checks++; if (s_addr !== e.addr) begin failures++; $display("FAIL rr_addr got=%h exp=%h", s_addr, e.addr); end
      end
    end
    @(negedge clk);
    m_valid = 3'b000;
    #1;
    checks++; if (grant !== 3'b000) begin failures++; $display("FAIL rr_final_release got=%b exp=000", grant); end
    checks++; if (beats != 4) begin failures++; $display("FAIL rr_beats got=%0d exp=4", beats); end
  endtask

  task automatic test_stall();
    beat_t e;
    int acc = 0;
    bit drop;
    exp_q.delete();
    for (int k = 0; k < 8; k++) exp_q.push_back('{1, 32'h2000, 32'hA000 + k});
    @(negedge clk);
    set_master(1, 32'h2000, 32'hA000, 4'hF, 8'd7);
    m_valid = 3'b010;
    s_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && acc < 8; cyc++) begin
      @(negedge clk);
      s_ready = (cyc % 2 == 0);
      drop = (cyc >= 4 && cyc < 8);
      m_valid[1] = !drop;
      m_valid[0] = (cyc >= 1 && cyc < 6);
      m_len[15:8] = (cyc >= 1) ? 8'd2 : 8'd7;
      m_wdata[63:32] = 32'hA000 + acc;
      #1;
      checks++; if (grant !== 3'b010 || busy !== 1'b1) begin failures++; $display("FAIL stall_grant_held got=%b/%b exp=010/1", grant, busy); end
      if (drop) begin
        checks++; if (s_valid !== 1'b0 || m_ready !== 3'b000) begin failures++; $display("FAIL stall_valid_drop got=%b/%b exp=0/000", s_valid, m_ready); end
      end
      if (m_ready !== 3'b000 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        acc++;
        checks++; if (m_ready !== 3'b010) begin failures++; $display("FAIL stall_ready got=%b exp=010", m_ready); end
        checks++; if (s_wdata !== e.wdata || s_wstrb !== 4'hF || s_len !== 8'd7) begin failures++; $display("FAIL stall_fields got=%h/%h/%h exp=%h/f/07", s_wdata, s_wstrb, s_len, e.wdata); end
      end
    end
    checks++; if (acc != 8) begin failures++; $display("FAIL stall_beats got=%0d exp=8", acc); end
    @(negedge clk);
    for (int m = 0; m < 3; m++) set_master(m, 32'h500 + m, 32'h0, 4'h0, 8'd0);
    m_valid = 3'b111;
    s_ready = 1'b1;
    #1;
    checks++; if (grant !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL stall_release got=%b/%b exp=000/0", grant, busy); end
    @(negedge clk);
    #1;
`ifdef DBUS_ARB_FIXED_PRIO_EN
    checks++; if (grant !== 3'b001) begin failures++; $display("FAIL stall_next_grant got=%b exp=001", grant); end
`else
    checks++; if (grant !== 3'b100) begin failures++; $display("FAIL stall_next_grant got=%b exp=100", grant); end
`endif
    @(negedge clk);
    m_valid = 3'b000;
    @(negedge clk);
    #1;
    checks++; if (grant !== 3'b000) begin failures++; $display("FAIL stall_idle_after got=%b exp=000", grant); end
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    // Serve m1 once so the rotation pointer moves to 2 before the burst.
    @(negedge clk);
    set_master(1, 32'h600, 32'h0, 4'h0, 8'd0);
    m_valid = 3'b010;
    s_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_valid = 3'b000;
    @(negedge clk);
    set_master(2, 32'h700, 32'h0, 4'h0, 8'd5);
    m_valid = 3'b100;
    for (int cyc = 0; cyc < 20 && acc < 2; cyc++) begin
      @(negedge clk);
      #1;
      if (m_ready !== 3'b000) begin
        acc++;
        checks++; if (m_ready !== 3'b100) begin failures++; $display("FAIL midrst_ready got=%b exp=100", m_ready); end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    m_valid = 3'b000;
    @(negedge clk);
    #1;
    checks++; if (grant !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state got=%b/%b exp=000/0", grant, busy); end
    checks++; if (s_valid !== 1'b0 || m_ready !== 3'b000) begin failures++; $display("FAIL midrst_outputs got=%b/%b exp=0/000", s_valid, m_ready); end
    rst = 1'b1;
    set_master(0, 32'h800, 32'h0, 4'h0, 8'd0);
    set_master(2, 32'h900, 32'h0, 4'h0, 8'd0);
    m_valid = 3'b101;
    @(negedge clk);
    #1;
    checks++; if (grant !== 3'b001 || s_addr !== 32'h800) begin failures++; $display("FAIL midrst_regrant got=%b/%h exp=001/00000800", grant, s_addr); end
    @(negedge clk);
    m_valid = 3'b000;
    @(negedge clk);
    #1;
    checks++; if (grant !== 3'b000) begin failures++; $display("FAIL midrst_final got=%b exp=000", grant); end
  endtask

`ifdef DBUS_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    int b0 = 0;
    int b2 = 0;
    bit ended = 0;
    @(negedge clk);
    set_master(0, 32'hA00, 32'h0, 4'h0, 8'd1);
    set_master(2, 32'hC00, 32'h0, 4'h0, 8'd1);
    m_valid = 3'b101;
    s_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      #1;
      if (grant !== 3'b000) begin
        checks++; if (grant !== 3'b001) begin failures++; $display("FAIL fixed_grant got=%b exp=001", grant); end
      end
      if (m_ready[0] === 1'b1) b0++;
      if (m_ready[2] === 1'b1) b2++;
    end
    for (int cyc = 0; cyc < 10 && !ended; cyc++) begin
      @(negedge clk);
      #1;
      if (busy === 1'b0) begin
        m_valid = 3'b000;
        ended = 1;
      end
    end
    checks++; if (b0 == 0) begin failures++; $display("FAIL fixed_m0_beats got=%0d exp=>0", b0); end
    checks++; if (b2 != 0) begin failures++; $display("FAIL fixed_m2_beats got=%0d exp=0", b2); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    m_valid = '0;
    m_addr = '0;
    m_wdata = '0;
    m_wstrb = '0;
    m_len = '0;
    s_rdata = '0;
    s_ready = 1'b0;
    test_reset();
    test_single_read();
`ifndef DBUS_ARB_FIXED_PRIO_EN
    test_rr();
`endif
    test_stall();
    test_reset_mid();
`ifdef DBUS_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
